// File: rtl/axis_corr_peak_detect_pkg.sv
// Shared definitions for the correlation peak detector: FSM encodings and
// the width helper used to size counters and indices.
package axis_corr_peak_detect_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;
    localparam logic [1:0] ST_EMIT   = 2'd3;

    // ceil(log2(value)), never below 1 so every derived vector has a bit
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/axis_corr_peak_detect_if.sv
// AXI-Stream style channel (valid/ready/data/dest) shared by the detector's
// input and output ports.
interface axis_corr_peak_detect_if
    import axis_corr_peak_detect_pkg::*;
#(
    parameter int DATA_W = 96,
    parameter int DEST_W = 1
) ();

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [DEST_W-1:0] tdest;

    modport master (output tvalid, output tdata, output tdest, input  tready);
    modport slave  (input  tvalid, input  tdata, input  tdest, output tready);

endinterface

// File: rtl/axis_corr_peak_detect_state.sv
// Per-correlator window state {beat_cnt, found, best_mag, best_idx} with one
// registered read port and one write port.
module corr_peak_state
    import axis_corr_peak_detect_pkg::*;
#(
    parameter int DEPTH  = 1,
    parameter int ADDR_W = 1,
    parameter int BEAT_W = 6,
    parameter int MAG_W  = 12,
    parameter int IDX_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [BEAT_W-1:0] rd_beat_o,
    output logic              rd_found_o,
    output logic [MAG_W-1:0]  rd_mag_o,
    output logic [IDX_W-1:0]  rd_idx_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [BEAT_W-1:0] wr_beat_i,
    input  logic              wr_found_i,
    input  logic [MAG_W-1:0]  wr_mag_i,
    input  logic [IDX_W-1:0]  wr_idx_i
);

    logic [BEAT_W-1:0] beat_q  [DEPTH];
    logic              found_q [DEPTH];
    logic [MAG_W-1:0]  mag_q   [DEPTH];
    logic [IDX_W-1:0]  idx_q   [DEPTH];

    logic [BEAT_W-1:0] rd_beat_q;
    logic              rd_found_q;
    logic [MAG_W-1:0]  rd_mag_q;
    logic [IDX_W-1:0]  rd_idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                beat_q[i]  <= '0;
                found_q[i] <= 1'b0;
                mag_q[i]   <= '0;
                idx_q[i]   <= '0;
            end
            rd_beat_q  <= '0;
            rd_found_q <= 1'b0;
            rd_mag_q   <= '0;
            rd_idx_q   <= '0;
        end else begin
            if (wr_en_i) begin
                beat_q[wr_addr_i]  <= wr_beat_i;
                found_q[wr_addr_i] <= wr_found_i;
                mag_q[wr_addr_i]   <= wr_mag_i;
                idx_q[wr_addr_i]   <= wr_idx_i;
            end
            // Reads and writes never target the same cycle: reads happen in IDLE, writes in UPDATE
            if (rd_en_i) begin
                rd_beat_q  <= beat_q[rd_addr_i];
                rd_found_q <= found_q[rd_addr_i];
                rd_mag_q   <= mag_q[rd_addr_i];
                rd_idx_q   <= idx_q[rd_addr_i];
            end
        end
    end

    assign rd_beat_o  = rd_beat_q;
    assign rd_found_o = rd_found_q;
    assign rd_mag_o   = rd_mag_q;
    assign rd_idx_o   = rd_idx_q;

endmodule

// File: rtl/axis_corr_peak_detect.sv
// Per-correlator windowed peak detector: scans one lane per cycle, keeps the
// earliest largest magnitude above threshold and emits one event per window.
module axis_corr_peak_detect
    import axis_corr_peak_detect_pkg::*;
#(
    parameter int NUM_PARALLEL = 8,
    parameter int ADDER_WIDTH  = 12,
    parameter int NUM_CORRS    = 1,
    parameter int WINDOW_BEATS = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDER_WIDTH-1:0]   threshold,
    axis_corr_peak_detect_if.slave   s_axis,
    axis_corr_peak_detect_if.master  m_axis
);

    localparam int INDEX_WIDTH = clog2_min1(WINDOW_BEATS * NUM_PARALLEL);
    localparam int LANE_W      = clog2_min1(NUM_PARALLEL);
    localparam int BEAT_W      = clog2_min1(WINDOW_BEATS);
    localparam int ADDR_W      = clog2_min1(NUM_CORRS);
    localparam int DATA_W      = NUM_PARALLEL * ADDER_WIDTH;
    localparam int OUT_W       = INDEX_WIDTH + ADDER_WIDTH;

    localparam logic [NUM_CORRS:0] NC_LIMIT  = (NUM_CORRS + 1)'(NUM_CORRS);
    localparam logic [LANE_W-1:0]  LANE_LAST = LANE_W'(NUM_PARALLEL - 1);
    localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(WINDOW_BEATS - 1);

    // Two's complement magnitude; the most negative value maps exactly to 2^(W-1)
    function automatic logic [ADDER_WIDTH-1:0] abs_mag(input logic signed [ADDER_WIDTH-1:0] x);
        logic [ADDER_WIDTH-1:0] u;
        u = x;
        return x[ADDER_WIDTH-1] ? (~u + ADDER_WIDTH'(1)) : u;
    endfunction

    logic [1:0]             state_q, state_d;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [ADDER_WIDTH-1:0] thr_q, thr_d;
    logic [NUM_CORRS-1:0]   dest_q, dest_d;
    logic                   wfound_q, wfound_d;
    logic [ADDER_WIDTH-1:0] wmag_q, wmag_d;
    logic [INDEX_WIDTH-1:0] widx_q, widx_d;
    logic [OUT_W-1:0]       pend_data_q, pend_data_d;
    logic [NUM_CORRS-1:0]   pend_dest_q, pend_dest_d;
    logic                   mvalid_q, mvalid_d;
    logic [OUT_W-1:0]       mdata_q, mdata_d;
    logic [NUM_CORRS-1:0]   mdest_q, mdest_d;

    logic                   rd_en, wr_en, wr_found;
    logic [BEAT_W-1:0]      rd_beat, wr_beat;
    logic                   rd_found;
    logic [ADDER_WIDTH-1:0] rd_mag, wr_mag;
    logic [INDEX_WIDTH-1:0] rd_idx, wr_idx;

    logic                   s_fire, dest_ok, out_free, m_fire, cand;
    logic signed [ADDER_WIDTH-1:0] lane_val;
    logic [ADDER_WIDTH-1:0] mag;
    logic                   src_found;
    logic [ADDER_WIDTH-1:0] src_mag;
    logic [INDEX_WIDTH-1:0] src_idx, scan_idx;

    assign s_axis.tready = (state_q == ST_IDLE) && !rst;
    assign s_fire        = s_axis.tvalid && s_axis.tready;
    assign dest_ok       = {1'b0, s_axis.tdest} < NC_LIMIT;
    assign m_fire        = mvalid_q && m_axis.tready;
    assign out_free      = !mvalid_q || m_axis.tready;

    // Lane 0 starts from the stored state; later lanes chain on the working copy
    assign lane_val  = data_q[lane_q*ADDER_WIDTH +: ADDER_WIDTH];
    assign mag       = abs_mag(lane_val);
    assign src_found = (lane_q == '0) ? rd_found : wfound_q;
    assign src_mag   = (lane_q == '0) ? rd_mag   : wmag_q;
    assign src_idx   = (lane_q == '0) ? rd_idx   : widx_q;
    assign scan_idx  = INDEX_WIDTH'(rd_beat) * INDEX_WIDTH'(NUM_PARALLEL) + INDEX_WIDTH'(lane_q);
    assign cand      = (mag > thr_q) && (!src_found || (mag > src_mag));

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        data_d      = data_q;
        thr_d       = thr_q;
        dest_d      = dest_q;
        wfound_d    = wfound_q;
        wmag_d      = wmag_q;
        widx_d      = widx_q;
        pend_data_d = pend_data_q;
        pend_dest_d = pend_dest_q;
        mvalid_d    = mvalid_q && !m_axis.tready;
        mdata_d     = mdata_q;
        mdest_d     = mdest_q;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        wr_beat     = '0;
        wr_found    = 1'b0;
        wr_mag      = '0;
        wr_idx      = '0;
        case (state_q)
            ST_IDLE: begin
                // Beats for nonexistent correlators are accepted and dropped
                if (s_fire && dest_ok) begin
                    data_d  = s_axis.tdata;
                    thr_d   = threshold;
                    dest_d  = s_axis.tdest;
                    lane_d  = '0;
                    rd_en   = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                wfound_d = src_found || cand;
                wmag_d   = cand ? mag : src_mag;
                widx_d   = cand ? scan_idx : src_idx;
                if (lane_q == LANE_LAST) begin
                    state_d = ST_UPDATE;
                end else begin
                    lane_d = lane_q + LANE_W'(1);
                end
            end
            ST_UPDATE: begin
                wr_en   = 1'b1;
                state_d = ST_IDLE;
                if (rd_beat != BEAT_LAST) begin
                    wr_beat  = rd_beat + BEAT_W'(1);
                    wr_found = wfound_q;
                    wr_mag   = wmag_q;
                    wr_idx   = widx_q;
                end else if (wfound_q) begin
                    if (out_free) begin
                        mvalid_d = 1'b1;
                        mdata_d  = {widx_q, wmag_q};
                        mdest_d  = dest_q;
                    end else begin
                        pend_data_d = {widx_q, wmag_q};
                        pend_dest_d = dest_q;
                        state_d     = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (m_fire) begin
                    mvalid_d = 1'b1;
                    mdata_d  = pend_data_q;
                    mdest_d  = pend_dest_q;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lane_q   <= '0;
            mvalid_q <= 1'b0;
            mdata_q  <= '0;
            mdest_q  <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            mvalid_q <= mvalid_d;
            mdata_q  <= mdata_d;
            mdest_q  <= mdest_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q      <= data_d;
        thr_q       <= thr_d;
        dest_q      <= dest_d;
        wfound_q    <= wfound_d;
        wmag_q      <= wmag_d;
        widx_q      <= widx_d;
        pend_data_q <= pend_data_d;
        pend_dest_q <= pend_dest_d;
    end

    corr_peak_state #(
        .DEPTH  (NUM_CORRS),
        .ADDR_W (ADDR_W),
        .BEAT_W (BEAT_W),
        .MAG_W  (ADDER_WIDTH),
        .IDX_W  (INDEX_WIDTH)
    ) u_state (
        .clk        (clk),
        .rst        (rst),
        .rd_en_i    (rd_en),
        .rd_addr_i  (s_axis.tdest[ADDR_W-1:0]),
        .rd_beat_o  (rd_beat),
        .rd_found_o (rd_found),
        .rd_mag_o   (rd_mag),
        .rd_idx_o   (rd_idx),
        .wr_en_i    (wr_en),
        .wr_addr_i  (dest_q[ADDR_W-1:0]),
        .wr_beat_i  (wr_beat),
        .wr_found_i (wr_found),
        .wr_mag_i   (wr_mag),
        .wr_idx_i   (wr_idx)
    );

    assign m_axis.tvalid = mvalid_q;
    assign m_axis.tdata  = mdata_q;
    assign m_axis.tdest  = mdest_q;

endmodule

// File: tb/tb_axis_corr_peak_detect.sv
// Bench for axis_corr_peak_detect: directed window scenarios plus random
// traffic, scored against a window-level reference model.
module tb_axis_corr_peak_detect;

    localparam int NP = 8;
    localparam int AW = 12;
    localparam int NC = 2;
    localparam int WB = 4;
    localparam int IW = 5;
    localparam int DW = NP * AW;
    localparam int OW = IW + AW;

    typedef struct packed {
        logic [1:0]    dest;
        logic [IW-1:0] idx;
        logic [AW-1:0] mag;
    } ev_t;

    logic          clk;
    logic          rst;
    logic [AW-1:0] threshold;
    int            checks;
    int            errors;
    int            bp_mode;
    ev_t           exp_q[$];
    int            win_mag[NC][WB*NP];
    int            win_thr[NC][WB*NP];
    int            win_cnt[NC];

    axis_corr_peak_detect_if #(.DATA_W(DW), .DEST_W(NC)) s_if ();
    axis_corr_peak_detect_if #(.DATA_W(OW), .DEST_W(NC)) m_if ();

    axis_corr_peak_detect #(
        .NUM_PARALLEL (NP),
        .ADDER_WIDTH  (AW),
        .NUM_CORRS    (NC),
        .WINDOW_BEATS (WB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .threshold (threshold),
        .s_axis    (s_if),
        .m_axis    (m_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NC; c++) win_cnt[c] = 0;
        exp_q.delete();
    endfunction

    // Window-level model: among samples above their own beat's threshold, the
    // largest magnitude wins and the earliest sample wins ties.
    function automatic void model_accept(input logic [1:0] dest, input logic [DW-1:0] data,
                                         input logic [AW-1:0] thr);
        int d, base, best, bidx, v;
        logic signed [AW-1:0] s;
        if (int'(dest) >= NC) return;
        d    = int'(dest);
        base = win_cnt[d] * NP;
        for (int k = 0; k < NP; k++) begin
            s = data[k*AW +: AW];
            v = s;
            win_mag[d][base+k] = (v < 0) ? -v : v;
            win_thr[d][base+k] = int'(thr);
        end
        win_cnt[d]++;
        if (win_cnt[d] == WB) begin
            best = -1;
            bidx = 0;
            for (int i = 0; i < WB*NP; i++) begin
                if (win_mag[d][i] > win_thr[d][i] && win_mag[d][i] > best) begin
                    best = win_mag[d][i];
                    bidx = i;
                end
            end
            if (best >= 0) exp_q.push_back('{dest: dest, idx: IW'(bidx), mag: AW'(best)});
            win_cnt[d] = 0;
        end
    endfunction

    function automatic logic [DW-1:0] beat1(input int lane, input int val);
        logic [DW-1:0] b;
        b = '0;
        if (lane >= 0) b[lane*AW +: AW] = AW'(val);
        return b;
    endfunction

    task automatic send_beat(input logic [1:0] dest, input logic [DW-1:0] data, input logic [AW-1:0] thr);
        int n;
        n = 0;
        @(negedge clk);
        s_if.tvalid = 1'b1;
        s_if.tdata  = data;
        s_if.tdest  = dest;
        threshold   = thr;
        while (!s_if.tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check_eq("in_timeout", n, 0);
            s_if.tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(dest, data, thr);
        #1 s_if.tvalid = 1'b0;
    endtask

    always @(posedge clk) begin
        #2;
        if (bp_mode == 1) m_if.tready = 1'($urandom_range(0, 1));
    end

    // Output monitor: ordering, content, and stability under backpressure
    logic          prev_stall;
    logic [OW-1:0] prev_data;
    logic [1:0]    prev_dest;
    ev_t           e;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", m_if.tvalid, 1);
                check_eq("hold_data", {m_if.tdest, m_if.tdata}, {prev_dest, prev_data});
            end
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = '1;
                check_eq("event", {m_if.tdest, m_if.tdata}, e);
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_data  = m_if.tdata;
            prev_dest  = m_if.tdest;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        logic [DW-1:0] b;
        int r, v;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        threshold = '0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tdest  = '0;
        m_if.tready = 1'b1;
        bp_mode = 0;
        model_reset();

        @(negedge clk);
        check_eq("rst_s_tready", s_if.tready, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_s_tready", s_if.tready, 1);
        check_eq("post_rst_m_tvalid", m_if.tvalid, 0);
        check_eq("post_rst_m_tdata", m_if.tdata, 0);
        check_eq("post_rst_m_tdest", m_if.tdest, 0);

        // Single negative peak, latency to event
        for (int i = 0; i < WB; i++) send_beat(2'd0, (i == 0) ? beat1(3, -300) : beat1(-1, 0), 12'd100);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_eq("t1_lat_early", m_if.tvalid, 0);
        @(posedge clk);
        @(negedge clk);
        check_eq("t1_lat_valid", m_if.tvalid, 1);
        check_eq("t1_data", m_if.tdata, {5'd3, 12'd300});
        check_eq("t1_dest", m_if.tdest, 0);
        check_eq("t1_s_tready", s_if.tready, 1);

        // Sub-threshold windows
        b = '0;
        for (int k = 0; k < NP; k++) b[k*AW +: AW] = 12'd50;
        for (int i = 0; i < 2*WB; i++) send_beat(2'd0, b, 12'd100);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check_eq("t2_no_event", m_if.tvalid, 0);

        // Tie keeps earliest; most-negative input
        send_beat(2'd0, beat1(2, 200), 12'd100);
        send_beat(2'd0, beat1(-1, 0), 12'd100);
        send_beat(2'd0, beat1(5, -200), 12'd100);
        send_beat(2'd0, beat1(-1, 0), 12'd100);
        send_beat(2'd0, beat1(-1, 0), 12'd100);
        send_beat(2'd0, beat1(7, -2048), 12'd100);
        send_beat(2'd0, beat1(-1, 0), 12'd100);
        send_beat(2'd0, beat1(-1, 0), 12'd100);
        repeat (12) @(posedge clk);
        check_eq("t3_drained", exp_q.size(), 0);

        // Interleaved correlators with an out-of-range dest in the middle
        for (int i = 0; i < 2*WB; i++) begin
            if (i == 2) send_beat(2'd0, beat1(1, 150), 12'd100);
            else if (i == 7) send_beat(2'd1, beat1(0, 500), 12'd100);
            else send_beat(2'(i % 2), beat1(-1, 0), 12'd100);
            if (i == 3) send_beat(2'd2, beat1(0, 1000), 12'd100);
        end
        repeat (12) @(posedge clk);
        check_eq("t4_drained", exp_q.size(), 0);

        // Both windows complete under backpressure
        @(posedge clk);
        #2 m_if.tready = 1'b0;
        for (int i = 0; i < WB; i++) send_beat(2'd0, (i == 2) ? beat1(4, 300) : beat1(-1, 0), 12'd100);
        for (int i = 0; i < WB; i++) send_beat(2'd1, (i == 0) ? beat1(6, -700) : beat1(-1, 0), 12'd100);
        repeat (NP + 4) @(negedge clk);
        check_eq("t5_emit_block", s_if.tready, 0);
        check_eq("t5_first_valid", m_if.tvalid, 1);
        check_eq("t5_first_data", {m_if.tdest, m_if.tdata}, {2'd0, 5'd20, 12'd300});
        @(posedge clk);
        #2 m_if.tready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq("t5_second_valid", m_if.tvalid, 1);
        check_eq("t5_second_data", {m_if.tdest, m_if.tdata}, {2'd1, 5'd6, 12'd700});
        check_eq("t5_release", s_if.tready, 1);
        repeat (4) @(posedge clk);
        check_eq("t5_drained", exp_q.size(), 0);

        // Reset mid-scan discards the recorded peak
        send_beat(2'd0, beat1(0, 400), 12'd100);
        send_beat(2'd0, beat1(-1, 0), 12'd100);
        send_beat(2'd0, beat1(-1, 0), 12'd100);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_s_tready", s_if.tready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_eq("t6_m_tvalid", m_if.tvalid, 0);
        check_eq("t6_s_tready", s_if.tready, 1);
        for (int i = 0; i < WB; i++) send_beat(2'd0, beat1(-1, 0), 12'd100);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check_eq("t6_no_old_peak", m_if.tvalid, 0);

        // Random traffic with random backpressure and thresholds
        bp_mode = 1;
        for (int i = 0; i < 60; i++) begin
            b = '0;
            for (int k = 0; k < NP; k++) begin
                r = int'($urandom_range(0, 7));
                if (r == 0) v = -2048;
                else if (r < 3) v = int'($urandom_range(0, 4095)) - 2048;
                else v = int'($urandom_range(0, 200)) - 100;
                b[k*AW +: AW] = AW'(v);
            end
            send_beat(2'($urandom_range(0, 3)), b, 12'($urandom_range(0, 700)));
        end
        bp_mode = 0;
        @(posedge clk);
        #2 m_if.tready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", exp_q.size(), 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("final_idle_valid", m_if.tvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
